// File: rtl/phi_sync_blink.sv
// Input conditioning for the CPU-bus FPGA: synchronizes PHI and async CPU signals into
// the i_clk domain, produces PHI edge pulses and derives two blink signals from a
// PHI rising-edge counter.
module phi_sync_blink #(
  parameter int unsigned WIDTH       = 20,
  parameter int unsigned SYNC_STAGES = 2,   // legal range 2..4
  parameter int unsigned CNT_WIDTH   = 24,
  parameter int unsigned BLINK1_BIT  = 23,  // must be < CNT_WIDTH
  parameter int unsigned BLINK2_BIT  = 22   // must be < CNT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_phi,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic             o_phi_sync,
  output logic             o_phi_rise,
  output logic             o_phi_fall,
  output logic             o_blink1,
  output logic             o_blink2
);

  // PHI rides along as the top bit so every bit gets its own identical flop chain.
  localparam int unsigned SyncW = WIDTH + 1;

  logic [SyncW-1:0]     sync_d [SYNC_STAGES];
  logic [SyncW-1:0]     sync_q [SYNC_STAGES];
  logic                 phi_sync;
  logic                 phi_prev_d, phi_prev_q;
  logic                 rise_d, rise_q;
  logic                 fall_d, fall_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

  assign phi_sync = sync_q[SYNC_STAGES-1][WIDTH];

  // Shift chain: stage 0 is the only one allowed to go metastable.
  always_comb begin
    sync_d[0] = {i_phi, i_async};
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Edge detection on the synchronized PHI and the rise-driven counter.
  always_comb begin
    phi_prev_d = phi_sync;
    rise_d     = phi_sync & ~phi_prev_q;
    fall_d     = ~phi_sync & phi_prev_q;
    cnt_d      = cnt_q + {{(CNT_WIDTH-1){1'b0}}, rise_q};
  end

  // Synchronizer stages.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  // Edge pulse registers and blink counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phi_prev_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      phi_prev_q <= phi_prev_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_sync     = sync_q[SYNC_STAGES-1][WIDTH-1:0];
  assign o_phi_sync = phi_sync;
  assign o_phi_rise = rise_q;
  assign o_phi_fall = fall_q;
  // Straight register bits, so the blink outputs cannot glitch.
  assign o_blink1   = cnt_q[BLINK1_BIT];
  assign o_blink2   = cnt_q[BLINK2_BIT];

endmodule

// File: tb/tb_phi_sync_blink.sv
// Directed bench for phi_sync_blink with a 4-bit counter so blink wrap is reachable.
module tb_phi_sync_blink;

  localparam int unsigned WIDTH = 20;

  logic             clk;
  logic             rst_n;
  logic             phi;
  logic [WIDTH-1:0] async_in;
  logic [WIDTH-1:0] sync_out;
  logic             phi_sync, phi_rise, phi_fall, blink1, blink2;

  int vectors     = 0;
  int miscompares = 0;
  int rise_seen   = 0;
  int fall_seen   = 0;
  int both_seen   = 0;

  phi_sync_blink #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(2),
    .CNT_WIDTH  (4),
    .BLINK1_BIT (3),
    .BLINK2_BIT (2)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_phi     (phi),
    .i_async   (async_in),
    .o_sync    (sync_out),
    .o_phi_sync(phi_sync),
    .o_phi_rise(phi_rise),
    .o_phi_fall(phi_fall),
    .o_blink1  (blink1),
    .o_blink2  (blink2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge and tally edge pulses seen there.
  task automatic tick();
    @(posedge clk);
    #1;
    rise_seen += int'(phi_rise);
    fall_seen += int'(phi_fall);
    if (phi_rise && phi_fall) both_seen++;
  endtask

  task automatic phi_pulse(input int hi, input int lo);
    phi = 1'b1;
    repeat (hi) tick();
    phi = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic clr_tally();
    rise_seen = 0;
    fall_seen = 0;
    both_seen = 0;
  endtask

  initial begin
    rst_n    = 1'b0;
    phi      = 1'b0;
    async_in = 20'hFFFFF;

    // Reset held with activity on the inputs.
    repeat (6) begin
      phi = ~phi;
      tick();
    end
    chk("rst_sync",     32'(sync_out), 32'h0);
    chk("rst_phi_sync", 32'(phi_sync), 32'h0);
    chk("rst_rise",     32'(phi_rise), 32'h0);
    chk("rst_fall",     32'(phi_fall), 32'h0);
    chk("rst_blink1",   32'(blink1),   32'h0);
    chk("rst_blink2",   32'(blink2),   32'h0);

    phi      = 1'b0;
    async_in = '0;
    rst_n    = 1'b1;
    repeat (3) tick();
    chk("idle_sync", 32'(sync_out), 32'h0);

    // Sync latency: visible after the second edge, not the first.
    async_in = 20'hA5A5A;
    tick();
    chk("sync_lat_early", 32'(sync_out), 32'h0);
    tick();
    chk("sync_lat", 32'(sync_out), 32'hA5A5A);

    // First PHI period, checked edge by edge (rise #1).
    clr_tally();
    phi = 1'b1;
    tick();
    chk("phi_sync_e1", 32'(phi_sync), 32'h0);
    tick();
    chk("phi_sync_e2", 32'(phi_sync), 32'h1);
    chk("rise_e2",     32'(phi_rise), 32'h0);
    tick();
    chk("rise_e3",     32'(phi_rise), 32'h1);
    chk("fall_e3",     32'(phi_fall), 32'h0);
    tick();
    chk("rise_e4",     32'(phi_rise), 32'h0);
    tick();
    phi = 1'b0;
    tick();
    chk("phi_sync_f1", 32'(phi_sync), 32'h1);
    tick();
    chk("phi_sync_f2", 32'(phi_sync), 32'h0);
    chk("fall_f2",     32'(phi_fall), 32'h0);
    tick();
    chk("fall_f3",     32'(phi_fall), 32'h1);
    chk("rise_f3",     32'(phi_rise), 32'h0);
    tick();
    chk("fall_f4",     32'(phi_fall), 32'h0);
    tick();

    // Rises 2..4 -> count 4.
    repeat (3) phi_pulse(5, 5);
    chk("rise_cnt_4",  32'(rise_seen), 32'd4);
    chk("fall_cnt_4",  32'(fall_seen), 32'd4);
    chk("both_hi",     32'(both_seen), 32'd0);
    chk("c4_blink2",   32'(blink2),    32'h1);
    chk("c4_blink1",   32'(blink1),    32'h0);

    repeat (4) phi_pulse(5, 5);
    chk("c8_blink1", 32'(blink1), 32'h1);
    chk("c8_blink2", 32'(blink2), 32'h0);

    repeat (8) phi_pulse(5, 5);
    chk("c16_blink1", 32'(blink1), 32'h0);
    chk("c16_blink2", 32'(blink2), 32'h0);

    // Six rises, then an asynchronous reset between clock edges.
    repeat (6) phi_pulse(5, 5);
    chk("c6_blink2", 32'(blink2), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_blink2", 32'(blink2),   32'h0);
    chk("arst_blink1", 32'(blink1),   32'h0);
    chk("arst_sync",   32'(sync_out), 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Restart: three rises -> count 3.
    repeat (3) phi_pulse(5, 5);
    chk("r3_blink2", 32'(blink2), 32'h0);

    // Slow PHI as the fourth rise: exactly one pulse, count 4.
    clr_tally();
    phi_pulse(100, 10);
    chk("slow_rise_cnt", 32'(rise_seen), 32'd1);
    chk("slow_fall_cnt", 32'(fall_seen), 32'd1);
    chk("r4_blink2",     32'(blink2),    32'h1);
    chk("r4_blink1",     32'(blink1),    32'h0);

    // A double increment from the slow phase would already show bit 3 here.
    repeat (3) phi_pulse(5, 5);
    chk("r7_blink1", 32'(blink1), 32'h0);
    chk("r7_blink2", 32'(blink2), 32'h1);
    phi_pulse(5, 5);
    chk("r8_blink1", 32'(blink1), 32'h1);
    chk("r8_blink2", 32'(blink2), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/phi_sync_blink.md
Name: phi_sync_blink

Overview:
- Input-conditioning block for the CPU-bus FPGA.
- Brings the asynchronous CPU clock (PHI) and a bus of asynchronous CPU signals (strobes, address) into the FPGA clock domain using multi-stage synchronizers.
- Produces single-cycle PHI edge pulses.
- Derives two free-running LED blink signals by counting PHI rising edges.

Parameters:
- WIDTH, 20, number of general asynchronous inputs synchronized in parallel.
- SYNC_STAGES, 2, flip-flop stages per synchronizer; legal range 2 to 4.
- CNT_WIDTH, 24, width of the PHI rising-edge counter.
- BLINK1_BIT, 23, counter bit driving o_blink1; must be less than CNT_WIDTH.
- BLINK2_BIT, 22, counter bit driving o_blink2; must be less than CNT_WIDTH.

Ports:
- i_clk  in  1  FPGA clock, 100 MHz. All state updates on its rising edge.
- i_rst_n  in  1  Asynchronous, active-low reset.
- i_phi  in  1  CPU clock (18.432 MHz), asynchronous to i_clk.
- i_async  in  WIDTH  Asynchronous level inputs.
- o_sync  out  WIDTH  Synchronized copy of i_async.
- o_phi_sync  out  1  Synchronized PHI level.
- o_phi_rise  out  1  One-cycle pulse on each synchronized PHI rising edge.
- o_phi_fall  out  1  One-cycle pulse on each synchronized PHI falling edge.
- o_blink1  out  1  Slow blink signal.
- o_blink2  out  1  Blink signal at twice the o_blink1 rate.

Behaviour:
- Reset: i_rst_n low asynchronously clears all synchronizer stages, o_sync, o_phi_sync, o_phi_rise, o_phi_fall, the counter, o_blink1 and o_blink2 to 0. The PHI previous-value register is also cleared to 0.
- Release of reset takes effect at the first i_clk rising edge after i_rst_n goes high.
- Synchronizers:
  - One independent SYNC_STAGES-deep flop chain per bit of i_async and for i_phi.
  - No combinational path from any input to any output.
  - A level change stable before edge n appears on o_sync / o_phi_sync after edge n+SYNC_STAGES-1 (2 edges with default settings).
  - Metastability is tolerated only in the first stage.
- Edge detect:
  - Register phi_prev samples o_phi_sync each cycle.
  - o_phi_rise is registered: set to (o_phi_sync & ~phi_prev), otherwise 0.
  - o_phi_fall is registered: set to (~o_phi_sync & phi_prev), otherwise 0.
  - Each pulse is exactly one i_clk cycle wide per PHI transition.
  - Pulses appear one cycle after o_phi_sync changes, i.e. SYNC_STAGES+1 edges after the input change (3 edges by default, 20–30 ns at 100 MHz).
  - o_phi_rise and o_phi_fall are never high in the same cycle.
  - If i_phi is high when reset releases, one o_phi_rise pulse is generated once the high level propagates. This is accepted behaviour.
- PHI period limit: the PHI high and low phases must each last at least 2 i_clk cycles to be captured. Narrower glitches may be missed; no other guarantee is made.
- Blink counter:
  - CNT_WIDTH-bit unsigned counter, incremented by 1 in the cycle after o_phi_rise is high.
  - Wraps from all-ones to 0 silently.
  - o_blink1 = counter[BLINK1_BIT]; o_blink2 = counter[BLINK2_BIT]. Both are direct register bits, so they are glitch-free.
  - Defaults give roughly 1.1 Hz and 2.2 Hz blink rates.
- Reset mid-operation: counter and pulses clear immediately. Counting restarts from 0 on the next detected rising edge.

Test Plan:
- Reset: hold i_rst_n=0 with i_phi toggling and i_async=20'hFFFFF -> all outputs 0. Assert reset asynchronously between clock edges -> outputs clear without waiting for a clock edge.
- Sync latency: after reset, i_async changes 0 -> 20'hA5A5A a setup time before edge n -> o_sync=20'hA5A5A after edge n+1, not before.
- PHI edge pulses: drive i_phi as a square wave with 5-cycle high and 5-cycle low phases -> o_phi_sync follows 2 edges late. o_phi_rise is a single-cycle pulse one edge after o_phi_sync rises; o_phi_fall likewise on the falling side; never both high.
- Counter/blink with override CNT_WIDTH=4, BLINK1_BIT=3, BLINK2_BIT=2: after 4 PHI rises -> o_blink2=1, o_blink1=0. After 8 -> o_blink1=1, o_blink2=0. After 16 -> both 0 (wrap).
- Mid-count reset: pulse i_rst_n low after 6 PHI rises -> counter 0, blinks 0. The next 4 rises set o_blink2=1.
- Slow PHI: i_phi held high for 100 cycles -> exactly one o_phi_rise pulse and a counter increment of exactly 1.
